// File: rtl/airlock_pressure_sequencer.sv
// airlock_pressure_sequencer: timed pressurize/vent cycles with hold, abort and persistent chamber flags
module airlock_pressure_sequencer #(
  parameter int CNT_W     = 8,
  parameter int PRESS_LEN = 8,
  parameter int VENT_LEN  = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start_press,
  input  logic             start_vent,
  input  logic             hold,
  input  logic             abort,
  output logic             busy,
  output logic [CNT_W-1:0] remaining,
  output logic             done,
  output logic             aborted,
  output logic             err,
  output logic             pressurized,
  output logic             depressurized
);
  typedef enum logic [1:0] {IDLE, PRESS, VENT, DONE} state_t;
  localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_LEN - 1);
  localparam logic [CNT_W-1:0] VENT_LOAD  = CNT_W'(VENT_LEN - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] rem_n;
  logic busy_n, done_n, aborted_n, err_n, press_n, vent_n;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      remaining     <= '0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      err           <= 1'b0;
      pressurized   <= 1'b0;
      depressurized <= 1'b0;
    end else begin
      state         <= state_n;
      busy          <= busy_n;
      remaining     <= rem_n;
      done          <= done_n;
      aborted       <= aborted_n;
      err           <= err_n;
      pressurized   <= press_n;
      depressurized <= vent_n;
    end
  end
  // the chamber flag set on entry to DONE is what records the cycle's origin
  always_comb begin
    state_n   = state;
    busy_n    = busy;
    rem_n     = remaining;
    done_n    = 1'b0;
    aborted_n = 1'b0;
    err_n     = 1'b0;
    press_n   = pressurized;
    vent_n    = depressurized;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        rem_n  = '0;
        if (start_press && start_vent) err_n = 1'b1;
        else if (start_press && pressurized) err_n = 1'b1;
        else if (start_vent && depressurized) err_n = 1'b1;
        else if (start_press || start_vent) begin
          state_n = start_press ? PRESS : VENT;
          rem_n   = start_press ? PRESS_LOAD : VENT_LOAD;
          busy_n  = 1'b1;
          press_n = 1'b0;
          vent_n  = 1'b0;
        end
      end
      PRESS, VENT: begin
        if (abort) begin
          state_n   = IDLE;
          busy_n    = 1'b0;
          rem_n     = '0;
          aborted_n = 1'b1;
          press_n   = 1'b0;
          vent_n    = 1'b0;
        end else if (!hold && remaining == '0) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          press_n = state == PRESS;
          vent_n  = state == VENT;
        end else if (!hold) rem_n = remaining - 1'b1;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        rem_n   = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_airlock_pressure_sequencer.sv
// tb_airlock_pressure_sequencer: directed checks of press/vent timing, hold, abort, err and reset
module tb_airlock_pressure_sequencer;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic start_press = 1'b0, start_vent = 1'b0, hold = 1'b0, abort = 1'b0, sp1 = 1'b0;
  logic busy, done, aborted, err, pressurized, depressurized;
  logic [7:0] remaining;
  logic busy1, done1, aborted1, err1, press1, vent1;
  logic [7:0] rem1;
  int checks = 0;
  int errors = 0;
  always #5 Clock = ~Clock;

  airlock_pressure_sequencer #(.CNT_W(8), .PRESS_LEN(8), .VENT_LEN(5)) dut (
    .Clock(Clock), .Reset(Reset), .start_press(start_press), .start_vent(start_vent),
    .hold(hold), .abort(abort), .busy(busy), .remaining(remaining), .done(done),
    .aborted(aborted), .err(err), .pressurized(pressurized), .depressurized(depressurized)
  );

  airlock_pressure_sequencer #(.CNT_W(8), .PRESS_LEN(1), .VENT_LEN(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .start_press(sp1), .start_vent(1'b0),
    .hold(1'b0), .abort(1'b0), .busy(busy1), .remaining(rem1), .done(done1),
    .aborted(aborted1), .err(err1), .pressurized(press1), .depressurized(vent1)
  );

  wire [13:0] obs  = {busy, remaining, done, aborted, err, pressurized, depressurized};
  wire [13:0] obs1 = {busy1, rem1, done1, aborted1, err1, press1, vent1};

  function automatic logic [13:0] pk(input logic b, input logic [7:0] r, input logic d,
                                     input logic a, input logic e, input logic p, input logic v);
    return {b, r, d, a, e, p, v};
  endfunction

  task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (busy,rem[8],done,abt,err,p,v)", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  initial begin
    step(2);
    chk("reset", obs, pk(0, 0, 0, 0, 0, 0, 0));
    Reset = 1'b0;
    start_press = 1'b1; step(1); start_press = 1'b0;
    chk("press_load", obs, pk(1, 7, 0, 0, 0, 0, 0));
    for (int i = 6; i >= 0; i--) begin
      step(1);
      chk($sformatf("press_rem%0d", i), obs, pk(1, 8'(i), 0, 0, 0, 0, 0));
    end
    step(1); chk("press_done", obs, pk(0, 0, 1, 0, 0, 1, 0));
    step(1); chk("press_idle", obs, pk(0, 0, 0, 0, 0, 1, 0));
    start_press = 1'b1; step(1); start_press = 1'b0;
    chk("press_while_pressurized", obs, pk(0, 0, 0, 0, 1, 1, 0));
    step(1); chk("err_one_cycle", obs, pk(0, 0, 0, 0, 0, 1, 0));
    start_vent = 1'b1; step(1); start_vent = 1'b0;
    chk("vent_load", obs, pk(1, 4, 0, 0, 0, 0, 0));
    step(2); chk("vent_rem2", obs, pk(1, 2, 0, 0, 0, 0, 0));
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk($sformatf("vent_hold%0d", i), obs, pk(1, 2, 0, 0, 0, 0, 0));
    end
    hold = 1'b0;
    step(1); chk("vent_rem1", obs, pk(1, 1, 0, 0, 0, 0, 0));
    step(1); chk("vent_rem0", obs, pk(1, 0, 0, 0, 0, 0, 0));
    step(1); chk("vent_done", obs, pk(0, 0, 1, 0, 0, 0, 1));
    step(1); chk("vent_idle", obs, pk(0, 0, 0, 0, 0, 0, 1));
    start_vent = 1'b1; step(1); start_vent = 1'b0;
    chk("vent_while_vented", obs, pk(0, 0, 0, 0, 1, 0, 1));
    start_press = 1'b1; step(1); start_press = 1'b0;
    chk("press2_load", obs, pk(1, 7, 0, 0, 0, 0, 0));
    step(4); chk("press2_rem3", obs, pk(1, 3, 0, 0, 0, 0, 0));
    abort = 1'b1; hold = 1'b1; step(1); abort = 1'b0; hold = 1'b0;
    chk("abort_with_hold", obs, pk(0, 0, 0, 1, 0, 0, 0));
    step(1); chk("after_abort", obs, pk(0, 0, 0, 0, 0, 0, 0));
    start_vent = 1'b1; step(1); start_vent = 1'b0;
    chk("vent_after_abort", obs, pk(1, 4, 0, 0, 0, 0, 0));
    start_press = 1'b1; start_vent = 1'b1; step(1); start_press = 1'b0; start_vent = 1'b0;
    chk("starts_ignored_busy", obs, pk(1, 3, 0, 0, 0, 0, 0));
    step(3); chk("vent2_rem0", obs, pk(1, 0, 0, 0, 0, 0, 0));
    abort = 1'b1; step(1); abort = 1'b0;
    chk("abort_at_rem0", obs, pk(0, 0, 0, 1, 0, 0, 0));
    start_vent = 1'b1; step(1); start_vent = 1'b0;
    step(5); chk("vent3_done", obs, pk(0, 0, 1, 0, 0, 0, 1));
    step(1);
    start_press = 1'b1; start_vent = 1'b1; step(1); start_press = 1'b0; start_vent = 1'b0;
    chk("both_starts", obs, pk(0, 0, 0, 0, 1, 0, 1));
    abort = 1'b1; hold = 1'b1; step(1); abort = 1'b0; hold = 1'b0;
    chk("abort_hold_idle", obs, pk(0, 0, 0, 0, 0, 0, 1));
    start_press = 1'b1; step(1); start_press = 1'b0;
    step(3); chk("press3_rem4", obs, pk(1, 4, 0, 0, 0, 0, 0));
    Reset = 1'b1; step(1); Reset = 1'b0;
    chk("reset_midcycle", obs, pk(0, 0, 0, 0, 0, 0, 0));
    start_press = 1'b1; step(1); start_press = 1'b0;
    step(8); chk("press4_done", obs, pk(0, 0, 1, 0, 0, 1, 0));
    Reset = 1'b1; step(1); Reset = 1'b0;
    chk("reset_in_done", obs, pk(0, 0, 0, 0, 0, 0, 0));
    chk("len1_idle", obs1, pk(0, 0, 0, 0, 0, 0, 0));
    sp1 = 1'b1; step(1); sp1 = 1'b0;
    chk("len1_busy", obs1, pk(1, 0, 0, 0, 0, 0, 0));
    step(1); chk("len1_done", obs1, pk(0, 0, 1, 0, 0, 1, 0));
    step(1); chk("len1_idle_after", obs1, pk(0, 0, 0, 0, 0, 1, 0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
